// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : Memory-access stage load/store unit. Takes the load/store
//               fields held in the EX/MEM register, runs the access over an
//               SRAM-like request/handshake bus, and returns the writeback
//               value for MEM/WB. Raises a stall while an access is in
//               flight, flags misaligned accesses (AdEL/AdES), and on flush
//               drains any access the bus has already accepted.
// Ports       : clk, rst (sync, active-high), flush
//               mem_*_i         - EX/MEM fields (op, address, store data,
//                                 ALU result, dest reg, write enable, upstream
//                                 exception flags)
//               wdata_o/wd_o/wreg_o - writeback toward MEM/WB
//               adel_o/ades_o/badvaddr_o - alignment exception report
//               stallreq_o      - stall request to pipeline control
//               data_*          - data-cache request/handshake bus
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [7:0]        mem_aluop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_reg2_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [4:0]        mem_wd_i,
    input  logic              mem_wreg_i,
    input  logic [31:0]       mem_excepttype_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [ADDR_W-1:0] badvaddr_o,
    output logic              stallreq_o,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    localparam logic [7:0] c_OP_LB  = 8'hE0;
    localparam logic [7:0] c_OP_LH  = 8'hE1;
    localparam logic [7:0] c_OP_LW  = 8'hE3;
    localparam logic [7:0] c_OP_LBU = 8'hE4;
    localparam logic [7:0] c_OP_LHU = 8'hE5;
    localparam logic [7:0] c_OP_SB  = 8'hE8;
    localparam logic [7:0] c_OP_SH  = 8'hE9;
    localparam logic [7:0] c_OP_SW  = 8'hEB;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;

    // Request fields are latched at launch so the bus sees stable values
    // for the whole REQ phase regardless of what the pipeline does.
    logic [7:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wr;
    logic [1:0]          r_size;
    logic [3:0]          r_strb;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_is_load;
    logic                w_is_store;
    logic                w_misalign;
    logic                w_go;
    logic [1:0]          w_size;
    logic [3:0]          w_strb;
    logic [DATA_W-1:0]   w_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DATA_W-1:0]   w_load_ext;

    // ---------------- decode and alignment ----------------
    assign w_is_load  = (mem_aluop_i == c_OP_LB)  || (mem_aluop_i == c_OP_LH) ||
                        (mem_aluop_i == c_OP_LW)  || (mem_aluop_i == c_OP_LBU) ||
                        (mem_aluop_i == c_OP_LHU);
    assign w_is_store = (mem_aluop_i == c_OP_SB)  || (mem_aluop_i == c_OP_SH) ||
                        (mem_aluop_i == c_OP_SW);

    assign w_misalign = (((mem_aluop_i == c_OP_LH) || (mem_aluop_i == c_OP_LHU) ||
                          (mem_aluop_i == c_OP_SH)) && mem_addr_i[0]) ||
                        (((mem_aluop_i == c_OP_LW) || (mem_aluop_i == c_OP_SW)) &&
                          (mem_addr_i[1:0] != 2'b00));

    assign adel_o     = w_is_load  && w_misalign;
    assign ades_o     = w_is_store && w_misalign;
    assign badvaddr_o = (adel_o || ades_o) ? mem_addr_i : '0;

    assign w_go = (w_is_load || w_is_store) && (mem_excepttype_i == 32'd0) &&
                  !w_misalign && !flush;

    // ---------------- store formatting ----------------
    always_comb begin
        w_size  = 2'd2;
        w_strb  = 4'b0000;
        w_wdata = mem_reg2_i;
        case (mem_aluop_i)
            c_OP_LB, c_OP_LBU: w_size = 2'd0;
            c_OP_LH, c_OP_LHU: w_size = 2'd1;
            c_OP_SB: begin
                w_size  = 2'd0;
                w_strb  = 4'b0001 << mem_addr_i[1:0];
                w_wdata = {4{mem_reg2_i[7:0]}};
            end
            c_OP_SH: begin
                w_size  = 2'd1;
                w_strb  = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{mem_reg2_i[15:0]}};
            end
            c_OP_SW: begin
                w_size  = 2'd2;
                w_strb  = 4'b1111;
                w_wdata = mem_reg2_i;
            end
            default: w_size = 2'd2;
        endcase
    end

    // ---------------- load lane select and extension ----------------
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = r_rdata[7:0];
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (r_op)
            c_OP_LB:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load_ext = {24'd0, w_byte};
            c_OP_LH:  w_load_ext = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load_ext = {16'd0, w_half};
            default:  w_load_ext = r_rdata;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_size  <= '0;
            r_strb  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && w_go) begin
                r_op    <= mem_aluop_i;
                r_addr  <= mem_addr_i;
                r_wr    <= w_is_store;
                r_size  <= w_size;
                r_strb  <= w_strb;
                r_wdata <= w_wdata;
            end
            if ((r_state == ST_WAIT) && data_data_ok) begin
                r_rdata <= data_rdata;
            end
        end
    end

    // ---------------- next state and stall ----------------
    always_comb begin
        w_next     = r_state;
        stallreq_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    stallreq_o = 1'b1;
                    w_next     = ST_REQ;
                end
            end
            ST_REQ: begin
                stallreq_o = 1'b1;
                // Once the bus has accepted the request a response is owed,
                // so a flush at that point must still wait it out.
                if (flush && data_addr_ok) w_next = ST_DRAIN;
                else if (flush)            w_next = ST_IDLE;
                else if (data_addr_ok)     w_next = ST_WAIT;
            end
            ST_WAIT: begin
                stallreq_o = 1'b1;
                if (flush && data_data_ok) w_next = ST_IDLE;
                else if (flush)            w_next = ST_DRAIN;
                else if (data_data_ok)     w_next = ST_DONE;
            end
            ST_DONE: begin
                // Stall released for one cycle so MEM/WB takes the result
                // and the pipeline moves the next instruction in.
                w_next = ST_IDLE;
            end
            ST_DRAIN: begin
                stallreq_o = 1'b1;
                if (data_data_ok) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // ---------------- bus and writeback outputs ----------------
    assign data_req   = (r_state == ST_REQ);
    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wdata = r_wdata;
    assign data_wstrb = r_strb;

    assign wdata_o = ((r_state == ST_DONE) && !r_wr) ? w_load_ext : mem_wdata_i;
    assign wd_o    = mem_wd_i;
    assign wreg_o  = mem_wreg_i && !adel_o && !(w_is_load && (r_state != ST_DONE)) &&
                     !flush && (r_state != ST_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_lsu
// Description : Self-checking bench for mem_lsu. Directed loads, stores,
//               misaligned accesses, flush in REQ/WAIT and reset in WAIT,
//               against a small bus slave with programmable latencies.
//               Expected writebacks go into a scoreboard queue that a
//               monitor pops whenever the stage releases its stall.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [7:0]  mem_aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_reg2_i;
    logic [31:0] mem_wdata_i;
    logic [4:0]  mem_wd_i;
    logic        mem_wreg_i;
    logic [31:0] mem_excepttype_i;
    logic [31:0] wdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic        adel_o;
    logic        ades_o;
    logic [31:0] badvaddr_o;
    logic        stallreq_o;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .mem_aluop_i      (mem_aluop_i),
        .mem_addr_i       (mem_addr_i),
        .mem_reg2_i       (mem_reg2_i),
        .mem_wdata_i      (mem_wdata_i),
        .mem_wd_i         (mem_wd_i),
        .mem_wreg_i       (mem_wreg_i),
        .mem_excepttype_i (mem_excepttype_i),
        .wdata_o          (wdata_o),
        .wd_o             (wd_o),
        .wreg_o           (wreg_o),
        .adel_o           (adel_o),
        .ades_o           (ades_o),
        .badvaddr_o       (badvaddr_o),
        .stallreq_o       (stallreq_o),
        .data_req         (data_req),
        .data_wr          (data_wr),
        .data_size        (data_size),
        .data_addr        (data_addr),
        .data_wdata       (data_wdata),
        .data_wstrb       (data_wstrb),
        .data_addr_ok     (data_addr_ok),
        .data_data_ok     (data_data_ok),
        .data_rdata       (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [37:0] sb_q[$];
    logic        capture_en = 1'b0;

    // slave configuration
    int          aok_dly = 1;
    int          dok_dly = 1;
    logic [31:0] slave_rdata = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic bubble();
        mem_aluop_i      = 8'h00;
        mem_addr_i       = 32'd0;
        mem_reg2_i       = 32'd0;
        mem_wdata_i      = 32'd0;
        mem_wd_i         = 5'd0;
        mem_wreg_i       = 1'b0;
        mem_excepttype_i = 32'd0;
        flush            = 1'b0;
    endtask

    // Bus slave: addr_ok after aok_dly cycles of data_req, data_ok
    // dok_dly cycles after the address handshake. A pending response is
    // delivered even if the master was reset meanwhile.
    initial begin : slave
        int   acnt;
        int   dcnt;
        logic pend;
        logic hs_a;
        logic hs_d;
        acnt = 0; dcnt = 0; pend = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            hs_a = data_req && data_addr_ok;
            hs_d = data_data_ok;
            @(posedge clk);
            #1;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            if (hs_d) pend = 1'b0;
            if (hs_a) begin
                pend = 1'b1;
                dcnt = 0;
                acnt = 0;
            end
            if (pend) begin
                dcnt++;
                if (dcnt >= dok_dly) begin
                    data_data_ok = 1'b1;
                    data_rdata   = slave_rdata;
                end
            end else if (data_req) begin
                acnt++;
                if (acnt >= aok_dly) data_addr_ok = 1'b1;
            end else begin
                acnt = 0;
            end
        end
    end

    // Monitor: the cycle the stall is released is the cycle MEM/WB captures.
    initial begin : monitor
        logic [37:0] exp_v;
        forever begin
            @(negedge clk);
            if (capture_en && !stallreq_o && !rst) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow actual={%h,%h,%b} expected=none", wdata_o, wd_o, wreg_o);
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({wdata_o, wd_o, wreg_o} !== exp_v) begin
                        errors++;
                        $display("FAIL writeback actual={wdata=%h wd=%h wreg=%b} expected={wdata=%h wd=%h wreg=%b}",
                                 wdata_o, wd_o, wreg_o, exp_v[37:6], exp_v[5:1], exp_v[0]);
                    end
                end
            end
        end
    end

    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [31:0] alu, input logic [4:0] wd,
                          input logic wreg, input logic [31:0] exc, input int aok, input int dok,
                          input logic [31:0] rd, input logic [31:0] exp_wdata, input logic exp_wreg,
                          input logic exp_req, input logic [1:0] exp_size, input logic [3:0] exp_strb,
                          input logic [31:0] exp_bwdata, input logic exp_adel, input logic exp_ades);
        logic saw_req;
        logic bad_wreg;
        logic timed_out;
        int   n;
        @(posedge clk);
        #1;
        mem_aluop_i      = op;
        mem_addr_i       = addr;
        mem_reg2_i       = reg2;
        mem_wdata_i      = alu;
        mem_wd_i         = wd;
        mem_wreg_i       = wreg;
        mem_excepttype_i = exc;
        flush            = 1'b0;
        aok_dly          = aok;
        dok_dly          = dok;
        slave_rdata      = rd;
        sb_q.push_back({exp_wdata, wd, exp_wreg});
        capture_en = 1'b1;
        saw_req = 1'b0; bad_wreg = 1'b0; timed_out = 1'b0; n = 0;
        while (1) begin
            @(negedge clk);
            if (!stallreq_o) break;
            if (wreg_o) bad_wreg = 1'b1;
            if (data_req && !saw_req) begin
                saw_req = 1'b1;
                check({tag, "_bus_addr"}, data_addr, addr);
                check({tag, "_bus_wr"},   data_wr, exp_strb != 4'd0);
                check({tag, "_bus_size"}, data_size, exp_size);
                check({tag, "_bus_strb"}, data_wstrb, exp_strb);
                if (exp_strb != 4'd0) check({tag, "_bus_wdata"}, data_wdata, exp_bwdata);
            end
            n++;
            if (n > 200) begin
                timed_out = 1'b1;
                break;
            end
        end
        check({tag, "_timeout"}, timed_out, 1'b0);
        check({tag, "_req_seen"}, saw_req, exp_req);
        check({tag, "_wreg_in_stall"}, bad_wreg, 1'b0);
        check({tag, "_adel"}, adel_o, exp_adel);
        check({tag, "_ades"}, ades_o, exp_ades);
        check({tag, "_badvaddr"}, badvaddr_o, (exp_adel || exp_ades) ? addr : 32'd0);
        @(posedge clk);
        #1;
        bubble();
        capture_en = 1'b0;
    endtask

    task automatic wait_handshake(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(data_req && data_addr_ok) && n < 100);
        check({tag, "_handshake"}, data_req && data_addr_ok, 1'b1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        logic seen_dok;
        logic bad;
        int   n;
        rst = 1'b1;
        bubble();
        repeat (3) @(negedge clk);
        check("rst_data_req", data_req, 1'b0);
        check("rst_stall",    stallreq_o, 1'b0);
        check("rst_wreg",     wreg_o, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //     tag       op     addr          reg2          alu           wd  wr exc         aok dok rdata         exp_wdata     ewr req size strb   bwdata        adel ades
        run_op("lw",     8'hE3, 32'h0000_1000, 32'h0,        32'h55,       5'd5, 1, 32'h0,      2, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 2'd2, 4'h0, 32'h0,        0, 0);
        run_op("lb",     8'hE0, 32'h0000_1003, 32'h0,        32'h0,        5'd6, 1, 32'h0,      1, 1, 32'h8012_3456, 32'hFFFF_FF80, 1, 1, 2'd0, 4'h0, 32'h0,       0, 0);
        run_op("lbu",    8'hE4, 32'h0000_1003, 32'h0,        32'h0,        5'd6, 1, 32'h0,      1, 2, 32'h8012_3456, 32'h0000_0080, 1, 1, 2'd0, 4'h0, 32'h0,       0, 0);
        run_op("lhu",    8'hE5, 32'h0000_0002, 32'h0,        32'h0,        5'd7, 1, 32'h0,      3, 1, 32'h8001_1234, 32'h0000_8001, 1, 1, 2'd1, 4'h0, 32'h0,       0, 0);
        run_op("lh",     8'hE1, 32'h0000_1000, 32'h0,        32'h0,        5'd8, 1, 32'h0,      1, 1, 32'h1234_8000, 32'hFFFF_8000, 1, 1, 2'd1, 4'h0, 32'h0,       0, 0);
        run_op("sh",     8'hE9, 32'h0000_2002, 32'h1234_ABCD, 32'h1111_1111, 5'd0, 0, 32'h0,     1, 2, 32'h0,        32'h1111_1111, 0, 1, 2'd1, 4'hC, 32'hABCD_ABCD, 0, 0);
        run_op("sb",     8'hE8, 32'h0000_3001, 32'h0000_00A5, 32'h0000_3001, 5'd0, 0, 32'h0,     2, 1, 32'h0,        32'h0000_3001, 0, 1, 2'd0, 4'h2, 32'hA5A5_A5A5, 0, 0);
        run_op("sw",     8'hEB, 32'h0000_4000, 32'hCAFE_F00D, 32'h0000_4000, 5'd0, 0, 32'h0,     1, 1, 32'h0,        32'h0000_4000, 0, 1, 2'd2, 4'hF, 32'hCAFE_F00D, 0, 0);
        run_op("lh_mis", 8'hE1, 32'h0000_1001, 32'h0,        32'h22,       5'd8, 1, 32'h0,      1, 1, 32'h0,        32'h22,        0, 0, 2'd1, 4'h0, 32'h0,       1, 0);
        run_op("sw_mis", 8'hEB, 32'h0000_0002, 32'hFFFF,     32'h33,       5'd0, 0, 32'h0,      1, 1, 32'h0,        32'h33,        0, 0, 2'd2, 4'hF, 32'h0,       0, 1);
        run_op("alu",    8'h21, 32'h0000_1234, 32'h0,        32'h1234_5678, 5'd7, 1, 32'h0,     1, 1, 32'h0,        32'h1234_5678, 1, 0, 2'd2, 4'h0, 32'h0,       0, 0);
        run_op("lw_exc", 8'hE3, 32'h0000_1000, 32'h0,        32'h44,       5'd9, 1, 32'h100,    1, 1, 32'h0,        32'h44,        0, 0, 2'd2, 4'h0, 32'h0,       0, 0);

        // flush while waiting for data: drain until data_ok, no writeback
        @(posedge clk);
        #1;
        mem_aluop_i = 8'hE3; mem_addr_i = 32'h0000_1000; mem_wd_i = 5'd3; mem_wreg_i = 1'b1;
        aok_dly = 1; dok_dly = 6; slave_rdata = 32'h5555_AAAA;
        wait_handshake("fw");
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("fw_stall", stallreq_o, 1'b1);
        check("fw_wreg",  wreg_o, 1'b0);
        @(posedge clk);
        #1;
        bubble();
        seen_dok = 1'b0; bad = 1'b0; n = 0;
        while (1) begin
            @(negedge clk);
            if (!stallreq_o) break;
            if (wreg_o) bad = 1'b1;
            if (data_data_ok) seen_dok = 1'b1;
            n++;
            if (n > 100) break;
        end
        check("drain_until_data_ok", seen_dok, 1'b1);
        check("drain_wreg",          bad, 1'b0);
        check("drain_req",           data_req, 1'b0);
        run_op("lw_post_drain", 8'hE3, 32'h0000_1004, 32'h0, 32'h0, 5'd4, 1, 32'h0, 1, 2,
               32'h0BAD_F00D, 32'h0BAD_F00D, 1, 1, 2'd2, 4'h0, 32'h0, 0, 0);

        // flush before address acceptance: request withdrawn next cycle
        @(posedge clk);
        #1;
        mem_aluop_i = 8'hE3; mem_addr_i = 32'h0000_1008; mem_wd_i = 5'd2; mem_wreg_i = 1'b1;
        aok_dly = 1000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_req && n < 20);
        check("fr_req_up", data_req, 1'b1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("fr_req_hold", data_req, 1'b1);
        @(posedge clk);
        #1;
        bubble();
        @(negedge clk);
        check("fr_req_drop", data_req, 1'b0);
        check("fr_stall",    stallreq_o, 1'b0);

        // reset while waiting for data; late data_ok must be ignored
        @(posedge clk);
        #1;
        mem_aluop_i = 8'hE3; mem_addr_i = 32'h0000_100C; mem_wd_i = 5'd1; mem_wreg_i = 1'b1;
        aok_dly = 1; dok_dly = 5; slave_rdata = 32'hFEED_FACE;
        wait_handshake("rw");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bubble();
        @(negedge clk);
        check("rw_req",   data_req, 1'b0);
        check("rw_stall", stallreq_o, 1'b0);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (stallreq_o || wreg_o || data_req) bad = 1'b1;
        end
        check("rw_late_dok_ignored", bad, 1'b0);
        run_op("lw_post_rst", 8'hE3, 32'h0000_1000, 32'h0, 32'h0, 5'd10, 1, 32'h0, 2, 2,
               32'h0123_4567, 32'h0123_4567, 1, 1, 2'd2, 4'h0, 32'h0, 0, 0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage core: consumes the load/store fields latched by the EX/MEM pipeline register and performs the data access over an SRAM-like request/handshake bus toward the data cache.
- Produces the writeback value for MEM/WB and raises a stall request while an access is in flight.
- Detects address-alignment exceptions (AdEL/AdES) and drains accepted accesses cleanly on flush.

Parameters:
- ADDR_W, 32, data bus address width
- DATA_W, 32, data bus data width (fixed 32; byte lanes = 4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush from exception control
- mem_aluop_i  in  8  op code (LB=E0, LH=E1, LW=E3, LBU=E4, LHU=E5, SB=E8, SH=E9, SW=EB hex; all other codes = non-memory)
- mem_addr_i  in  32  effective address
- mem_reg2_i  in  32  store source register value
- mem_wdata_i  in  32  ALU result for non-memory ops
- mem_wd_i  in  5  destination register address
- mem_wreg_i  in  1  destination write enable
- mem_excepttype_i  in  32  exceptions already flagged upstream
- wdata_o  out  32  writeback value
- wd_o  out  5  destination register address (pass-through)
- wreg_o  out  1  destination write enable
- adel_o  out  1  load address error
- ades_o  out  1  store address error
- badvaddr_o  out  32  faulting address
- stallreq_o  out  1  stall request to pipeline control
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  bus address
- data_wdata  out  32  bus write data
- data_wstrb  out  4  byte-lane write strobes
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write complete
- data_rdata  in  32  read data

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN. Reset → IDLE. Reset outputs: data_req = 0, stallreq_o = 0, wreg_o = 0, rdata register = 0. All registered state is cleared regardless of any transaction in progress; a data_data_ok seen in IDLE is ignored.
- go = memory op AND mem_excepttype_i == 0 AND no alignment error AND flush == 0.
- Alignment errors: half op with addr[0] = 1; word op with addr[1:0] != 0. Error on a load sets adel_o; error on a store sets ades_o. badvaddr_o = mem_addr_i whenever either flag is set, else 0. Both are combinational; an errored access issues no request.
- IDLE: if go, stallreq_o = 1 combinationally and next state = REQ.
- REQ: data_req = 1; data_addr, data_size, data_wr, data_wstrb, data_wdata are held stable. On data_addr_ok, go to WAIT.
- WAIT: on data_data_ok, capture data_rdata and go to DONE.
- DONE: stallreq_o = 0 for exactly one cycle so MEM/WB captures the result; then go to IDLE. Inputs advance at the end of this cycle, so the same instruction is never re-issued.
- stallreq_o = 1 in IDLE when go is true, and in REQ, WAIT and DRAIN.
- Flush in REQ before addr_ok: drop data_req next cycle and go to IDLE.
- Flush in REQ coincident with addr_ok, or flush in WAIT: go to DRAIN. DRAIN waits for data_data_ok, discards the data, then goes to IDLE. stallreq_o stays 1 in DRAIN; no writeback.
- Store data: data_wdata = reg2 byte replicated ×4 (SB), halfword replicated ×2 (SH), or the word (SW).
- Store strobes: SB: 0001 << addr[1:0]. SH: 0011 (addr[1] = 0) or 1100 (addr[1] = 1). SW: 1111. Loads: wstrb = 0000.
- data_addr = mem_addr_i. data_size is set from the op; size is not used to realign the address.
- Load data: select byte lane addr[1:0] (little-endian) or halfword lane addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- wdata_o = extended load data for loads in DONE, else mem_wdata_i. wd_o = mem_wd_i.
- wreg_o = mem_wreg_i AND NOT adel_o AND NOT (load not in DONE) AND NOT flush.

Test Plan:
- LW addr 0x0000_1000: addr_ok 2 cycles after req, data_ok 3 cycles later with rdata 0xDEADBEEF → stallreq_o high throughout, wdata_o = 0xDEADBEEF with wreg_o = 1 for exactly one cycle, then IDLE.
- LB addr 0x0000_1003, rdata 0x80xx_xxxx → wdata_o = 0xFFFF_FF80. LBU same → 0x0000_0080. LHU addr 0x2, rdata 0x8001_xxxx → 0x0000_8001.
- SH addr 0x0000_2002, reg2 0x1234_ABCD → data_wr = 1, data_size = 1, data_wstrb = 1100, data_wdata = 0xABCD_ABCD; completes on data_ok with wreg_o = 0.
- LH addr 0x0000_1001 → adel_o = 1, badvaddr_o = 0x0000_1001, data_req never asserted, stallreq_o = 0. SW addr 0x2 → ades_o = 1.
- LW accepted (addr_ok), flush in WAIT → DRAIN, stallreq_o held until data_ok, wreg_o = 0, next op issues normally. Flush in REQ before addr_ok → data_req drops next cycle.
- rst asserted in WAIT → next cycle IDLE, data_req = 0, stallreq_o = 0. Late data_ok ignored; subsequent LW completes correctly.
